pueo_trig_merge: RTL and testbench

Sysclk-domain trigger merger that sits directly downstream of the TURF trigger control block and the RF level-two trigger path. It samples the four phase-aligned trigger sources (RF, external, PPS, soft) once per 8-clock sysclk phase slot and selects at most one winner per slot by fixed priority. It applies the run holdoff, queues accepted triggers in a 4-deep buffer, and presents them on a valid/ready stream to the event builder. Rejected triggers are counted for monitoring.

---
 rtl/pueo_trig_pkg.sv | 28 ++
 rtl/pueo_trig_merge_fifo.sv | 55 +++++
 rtl/pueo_trig_merge.sv | 166 ++++++++++++++++
 tb/tb_pueo_trig_merge.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pueo_trig_pkg.sv
// Shared types for the sysclk trigger merger: source codes, queued entry layout and
// small arithmetic helpers.
package pueo_trig_pkg;

    localparam logic [1:0] TRIG_SRC_RF   = 2'd0;
    localparam logic [1:0] TRIG_SRC_EXT  = 2'd1;
    localparam logic [1:0] TRIG_SRC_PPS  = 2'd2;
    localparam logic [1:0] TRIG_SRC_SOFT = 2'd3;

    localparam int unsigned NUM_SRC = 4;

    typedef struct packed {
        logic [1:0]  source;
        logic [7:0]  metadata;
        logic [11:0] addr;
    } trig_entry_t;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {14'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/pueo_trig_merge_fifo.sv
// First-word-fall-through synchronous FIFO of trigger entries. A push while full is
// dropped even if a pop happens in the same cycle.
module pueo_trig_merge_fifo
    import pueo_trig_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  trig_entry_t data_i,
    input  logic        pop_i,
    output trig_entry_t data_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    trig_entry_t mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/pueo_trig_merge.sv
// Samples four trigger sources once per sysclk phase slot, picks one by fixed priority,
// applies holdoff and queues accepted triggers for the event builder.
module pueo_trig_merge
    import pueo_trig_pkg::*;
#(
    parameter int unsigned CAPTURE_PHASE = 4,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic        sysclk_i,
    input  logic        sysclk_rst_i,
    input  logic        sysclk_phase_i,
    input  logic        running_i,
    input  logic        rf_en_i,
    input  logic [15:0] holdoff_i,
    input  logic [11:0] rf_trig_i,
    input  logic [11:0] ext_trig_i,
    input  logic [11:0] pps_trig_i,
    input  logic [11:0] soft_trig_i,
    input  logic [7:0]  rf_metadata_i,
    input  logic [7:0]  ext_metadata_i,
    input  logic [7:0]  pps_metadata_i,
    input  logic [7:0]  soft_metadata_i,
    input  logic        rf_valid_i,
    input  logic        ext_valid_i,
    input  logic        pps_valid_i,
    input  logic        soft_valid_i,
    output logic [11:0] trig_o,
    output logic [7:0]  trig_metadata_o,
    output logic [1:0]  trig_source_o,
    output logic        trig_valid_o,
    input  logic        trig_ready_i,
    output logic [15:0] holdoff_rej_o,
    output logic [15:0] coinc_rej_o,
    output logic [15:0] overflow_rej_o
);

    localparam logic [2:0] CAP_PHASE = 3'(CAPTURE_PHASE);

    logic [2:0]  phase_q;
    logic        cap_hit;
    logic        cap_stb_q;
    logic [3:0]  cap_valid_q;
    trig_entry_t cap_entry_q [NUM_SRC];

    logic        decide;
    logic        hold_busy;
    logic        push;
    logic        fifo_full;
    logic        fifo_empty;
    trig_entry_t win_entry;
    trig_entry_t head;
    logic [2:0]  lose_inc;
    logic [2:0]  hold_inc;
    logic [2:0]  ovf_inc;
    logic [15:0] holdoff_q;
    logic [15:0] holdoff_d;
    logic [15:0] holdoff_rej_q;
    logic [15:0] coinc_rej_q;
    logic [15:0] overflow_rej_q;

    // Free-running slot counter; the phase pulse only realigns it.
    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i || sysclk_phase_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_q + 3'd1;
        end
    end

    assign cap_hit = (phase_q == CAP_PHASE);

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            cap_stb_q   <= 1'b0;
            cap_valid_q <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cap_entry_q[i] <= '0;
            end
        end else begin
            cap_stb_q <= cap_hit;
            if (cap_hit) begin
                cap_valid_q    <= {soft_valid_i, pps_valid_i, ext_valid_i, rf_valid_i & rf_en_i};
                cap_entry_q[0] <= '{source: TRIG_SRC_RF, metadata: rf_metadata_i,
                                    addr: rf_trig_i};
                cap_entry_q[1] <= '{source: TRIG_SRC_EXT, metadata: ext_metadata_i,
                                    addr: ext_trig_i};
                cap_entry_q[2] <= '{source: TRIG_SRC_PPS, metadata: pps_metadata_i,
                                    addr: pps_trig_i};
                cap_entry_q[3] <= '{source: TRIG_SRC_SOFT, metadata: soft_metadata_i,
                                    addr: soft_trig_i};
            end
        end
    end

    always_comb begin
        if (cap_valid_q[0]) begin
            win_entry = cap_entry_q[0];
        end else if (cap_valid_q[1]) begin
            win_entry = cap_entry_q[1];
        end else if (cap_valid_q[2]) begin
            win_entry = cap_entry_q[2];
        end else begin
            win_entry = cap_entry_q[3];
        end
    end

    assign decide    = cap_stb_q && running_i && (cap_valid_q != 4'd0);
    assign hold_busy = (holdoff_q != 16'd0);
    assign push      = decide && !hold_busy && !fifo_full;
    assign lose_inc  = decide ? (popcount4(cap_valid_q) - 3'd1) : 3'd0;
    assign hold_inc  = {2'b00, decide && hold_busy};
    assign ovf_inc   = {2'b00, decide && !hold_busy && fifo_full};

    always_comb begin
        holdoff_d = holdoff_q;
        if (!running_i) begin
            holdoff_d = '0;
        end else if (push) begin
            holdoff_d = holdoff_i;
        end else if (holdoff_q != 16'd0) begin
            holdoff_d = holdoff_q - 16'd1;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i) begin
            holdoff_q <= '0;
        end else begin
            holdoff_q <= holdoff_d;
        end
    end

    always_ff @(posedge sysclk_i) begin
        if (sysclk_rst_i || !running_i) begin
            holdoff_rej_q  <= '0;
            coinc_rej_q    <= '0;
            overflow_rej_q <= '0;
        end else begin
            holdoff_rej_q  <= sat_add16(holdoff_rej_q, hold_inc);
            coinc_rej_q    <= sat_add16(coinc_rej_q, lose_inc);
            overflow_rej_q <= sat_add16(overflow_rej_q, ovf_inc);
        end
    end

    pueo_trig_merge_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (sysclk_i),
        .rst_i   (sysclk_rst_i),
        .push_i  (push),
        .data_i  (win_entry),
        .pop_i   (trig_valid_o && trig_ready_i),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign trig_valid_o    = !fifo_empty;
    assign trig_o          = head.addr;
    assign trig_metadata_o = head.metadata;
    assign trig_source_o   = head.source;
    assign holdoff_rej_o   = holdoff_rej_q;
    assign coinc_rej_o     = coinc_rej_q;
    assign overflow_rej_o  = overflow_rej_q;

endmodule

// File: tb/tb_pueo_trig_merge.sv
// Bench for pueo_trig_merge: directed vector table, hand-written corner sequences and
// randomized slots, all checked every cycle against a queue/timestamp reference model.
module tb_pueo_trig_merge;
    import pueo_trig_pkg::*;

    logic        sysclk_i        = 1'b0;
    logic        sysclk_rst_i    = 1'b1;
    logic        sysclk_phase_i  = 1'b0;
    logic        running_i       = 1'b0;
    logic        rf_en_i         = 1'b1;
    logic [15:0] holdoff_i       = '0;
    logic [11:0] rf_trig_i       = '0;
    logic [11:0] ext_trig_i      = '0;
    logic [11:0] pps_trig_i      = '0;
    logic [11:0] soft_trig_i     = '0;
    logic [7:0]  rf_metadata_i   = '0;
    logic [7:0]  ext_metadata_i  = '0;
    logic [7:0]  pps_metadata_i  = '0;
    logic [7:0]  soft_metadata_i = '0;
    logic        rf_valid_i      = 1'b0;
    logic        ext_valid_i     = 1'b0;
    logic        pps_valid_i     = 1'b0;
    logic        soft_valid_i    = 1'b0;
    logic        trig_ready_i    = 1'b0;
    logic [11:0] trig_o;
    logic [7:0]  trig_metadata_o;
    logic [1:0]  trig_source_o;
    logic        trig_valid_o;
    logic [15:0] holdoff_rej_o;
    logic [15:0] coinc_rej_o;
    logic [15:0] overflow_rej_o;

    always #5 sysclk_i = ~sysclk_i;

    pueo_trig_merge #(
        .CAPTURE_PHASE (4),
        .FIFO_DEPTH    (4)
    ) dut (
        .sysclk_i        (sysclk_i),
        .sysclk_rst_i    (sysclk_rst_i),
        .sysclk_phase_i  (sysclk_phase_i),
        .running_i       (running_i),
        .rf_en_i         (rf_en_i),
        .holdoff_i       (holdoff_i),
        .rf_trig_i       (rf_trig_i),
        .ext_trig_i      (ext_trig_i),
        .pps_trig_i      (pps_trig_i),
        .soft_trig_i     (soft_trig_i),
        .rf_metadata_i   (rf_metadata_i),
        .ext_metadata_i  (ext_metadata_i),
        .pps_metadata_i  (pps_metadata_i),
        .soft_metadata_i (soft_metadata_i),
        .rf_valid_i      (rf_valid_i),
        .ext_valid_i     (ext_valid_i),
        .pps_valid_i     (pps_valid_i),
        .soft_valid_i    (soft_valid_i),
        .trig_o          (trig_o),
        .trig_metadata_o (trig_metadata_o),
        .trig_source_o   (trig_source_o),
        .trig_valid_o    (trig_valid_o),
        .trig_ready_i    (trig_ready_i),
        .holdoff_rej_o   (holdoff_rej_o),
        .coinc_rej_o     (coinc_rej_o),
        .overflow_rej_o  (overflow_rej_o)
    );

    // Reference model: absolute cycle numbers, a queue of accepted entries, plain ints.
    int          cyc      = 0;
    int          anchor   = 0;
    bit          cap_pend = 1'b0;
    logic [3:0]  cap_v    = '0;
    trig_entry_t cap_e [4];
    trig_entry_t mq [$];
    int          m_hold   = 0;
    int          m_coinc  = 0;
    int          m_ovf    = 0;
    bit          have_acc = 1'b0;
    int          last_acc = 0;
    int          last_h   = 0;
    int          total    = 0;
    int          bad      = 0;

    typedef struct packed {
        logic [3:0]       valid;
        logic             rf_en;
        logic [3:0][11:0] addr;
        logic [3:0][7:0]  meta;
        logic [1:0]       exp_src;
        logic [11:0]      exp_addr;
        logic [7:0]       exp_meta;
        logic [15:0]      exp_coinc;
    } vec_t;

    vec_t vecs [5];

    function automatic int sat(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance the model by the cycle whose inputs the DUT has just sampled.
    task automatic model_edge();
        int ph;
        int n_start;
        int w;
        if (sysclk_rst_i) begin
            mq.delete();
            m_hold   = 0;
            m_coinc  = 0;
            m_ovf    = 0;
            cap_pend = 1'b0;
            have_acc = 1'b0;
            anchor   = cyc + 1;
            cyc++;
            return;
        end
        ph      = (cyc - anchor) % 8;
        n_start = mq.size();
        if (n_start != 0 && trig_ready_i) mq.delete(0);
        if (cap_pend && running_i && cap_v != 4'd0) begin
            w = 0;
            while (!cap_v[w]) w++;
            m_coinc = sat(m_coinc + $countones(cap_v) - 1);
            // Holdoff of H accepted at cycle t blocks any decision at most H cycles later.
            if (have_acc && (cyc - last_acc) <= last_h) begin
                m_hold = sat(m_hold + 1);
            end else if (n_start >= 4) begin
                m_ovf = sat(m_ovf + 1);
            end else begin
                mq.push_back(cap_e[w]);
                have_acc = 1'b1;
                last_acc = cyc;
                last_h   = int'(holdoff_i);
            end
        end
        if (!running_i) begin
            m_hold   = 0;
            m_coinc  = 0;
            m_ovf    = 0;
            have_acc = 1'b0;
        end
        cap_pend = (ph == 4);
        if (cap_pend) begin
            cap_v    = {soft_valid_i, pps_valid_i, ext_valid_i, rf_valid_i & rf_en_i};
            cap_e[0] = '{source: TRIG_SRC_RF, metadata: rf_metadata_i, addr: rf_trig_i};
            cap_e[1] = '{source: TRIG_SRC_EXT, metadata: ext_metadata_i, addr: ext_trig_i};
            cap_e[2] = '{source: TRIG_SRC_PPS, metadata: pps_metadata_i, addr: pps_trig_i};
            cap_e[3] = '{source: TRIG_SRC_SOFT, metadata: soft_metadata_i,
                         addr: soft_trig_i};
        end
        if (sysclk_phase_i) anchor = cyc + 1;
        cyc++;
    endtask

    task automatic step();
        @(posedge sysclk_i);
        model_edge();
        #1;
        check("valid", {31'b0, trig_valid_o}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            check("addr", {20'b0, trig_o}, {20'b0, mq[0].addr});
            check("meta", {24'b0, trig_metadata_o}, {24'b0, mq[0].metadata});
            check("source", {30'b0, trig_source_o}, {30'b0, mq[0].source});
        end
        check("holdoff_rej", {16'b0, holdoff_rej_o}, m_hold);
        check("coinc_rej", {16'b0, coinc_rej_o}, m_coinc);
        check("overflow_rej", {16'b0, overflow_rej_o}, m_ovf);
    endtask

    task automatic set_src(input logic [3:0] v, input logic [3:0][11:0] a,
                           input logic [3:0][7:0] m);
        rf_valid_i      = v[0];
        ext_valid_i     = v[1];
        pps_valid_i     = v[2];
        soft_valid_i    = v[3];
        rf_trig_i       = a[0];
        ext_trig_i      = a[1];
        pps_trig_i      = a[2];
        soft_trig_i     = a[3];
        rf_metadata_i   = m[0];
        ext_metadata_i  = m[1];
        pps_metadata_i  = m[2];
        soft_metadata_i = m[3];
    endtask

    task automatic slot(input logic [3:0] v, input logic [3:0][11:0] a,
                        input logic [3:0][7:0] m, input bit pulse, input bit rnd_ready,
                        input int rst_at);
        set_src(v, a, m);
        sysclk_phase_i = pulse;
        for (int k = 0; k < 8; k++) begin
            if (rnd_ready) trig_ready_i = ($urandom_range(0, 2) != 0);
            sysclk_rst_i = (k == rst_at);
            step();
            sysclk_phase_i = 1'b0;
        end
        sysclk_rst_i = 1'b0;
    endtask

    // Drop running to clear counters and holdoff, drain the queue, then start a new run.
    task automatic new_run(input logic [15:0] h);
        running_i    = 1'b0;
        trig_ready_i = 1'b1;
        holdoff_i    = h;
        set_src('0, '0, '0);
        repeat (8) step();
        running_i    = 1'b1;
        trig_ready_i = 1'b0;
    endtask

    initial begin
        int n;
        logic [15:0] h_opts [7];
        h_opts = '{16'd0, 16'd5, 16'd7, 16'd8, 16'd9, 16'd16, 16'd30};

        vecs[0] = '{valid: 4'b1000, rf_en: 1'b1,
                    addr: {12'h123, 12'h000, 12'h000, 12'h000},
                    meta: {8'h80, 8'h00, 8'h00, 8'h00},
                    exp_src: 2'd3, exp_addr: 12'h123, exp_meta: 8'h80, exp_coinc: 16'd0};
        vecs[1] = '{valid: 4'b1111, rf_en: 1'b1,
                    addr: {12'h333, 12'h222, 12'h111, 12'h010},
                    meta: {8'h44, 8'h33, 8'h22, 8'h11},
                    exp_src: 2'd0, exp_addr: 12'h010, exp_meta: 8'h11, exp_coinc: 16'd3};
        vecs[2] = '{valid: 4'b0101, rf_en: 1'b0,
                    addr: {12'h000, 12'h0AB, 12'h000, 12'h0CD},
                    meta: {8'h00, 8'h5A, 8'h00, 8'hA5},
                    exp_src: 2'd2, exp_addr: 12'h0AB, exp_meta: 8'h5A, exp_coinc: 16'd0};
        vecs[3] = '{valid: 4'b1010, rf_en: 1'b1,
                    addr: {12'hFFF, 12'h000, 12'h456, 12'h000},
                    meta: {8'h01, 8'h00, 8'hFE, 8'h00},
                    exp_src: 2'd1, exp_addr: 12'h456, exp_meta: 8'hFE, exp_coinc: 16'd1};
        vecs[4] = '{valid: 4'b1101, rf_en: 1'b1,
                    addr: {12'hAAA, 12'hBBB, 12'h000, 12'hCCC},
                    meta: {8'h01, 8'h02, 8'h00, 8'h03},
                    exp_src: 2'd0, exp_addr: 12'hCCC, exp_meta: 8'h03, exp_coinc: 16'd2};

        // Reset state.
        repeat (3) step();
        check("rst_valid", {31'b0, trig_valid_o}, 0);
        check("rst_addr", {20'b0, trig_o}, 0);
        check("rst_meta", {24'b0, trig_metadata_o}, 0);
        check("rst_source", {30'b0, trig_source_o}, 0);
        sysclk_rst_i = 1'b0;

        // Directed vector table: one slot each, entry checked against table constants.
        for (int i = 0; i < 5; i++) begin
            new_run(16'd0);
            rf_en_i = vecs[i].rf_en;
            slot(vecs[i].valid, vecs[i].addr, vecs[i].meta, 1'b1, 1'b0, -1);
            check("vec_valid", {31'b0, trig_valid_o}, 1);
            check("vec_src", {30'b0, trig_source_o}, {30'b0, vecs[i].exp_src});
            check("vec_addr", {20'b0, trig_o}, {20'b0, vecs[i].exp_addr});
            check("vec_meta", {24'b0, trig_metadata_o}, {24'b0, vecs[i].exp_meta});
            check("vec_coinc", {16'b0, coinc_rej_o}, {16'b0, vecs[i].exp_coinc});
            check("vec_hold", {16'b0, holdoff_rej_o}, 0);
            rf_en_i = 1'b1;
        end

        // Latency: head valid appears two cycles after the capture cycle.
        new_run(16'd0);
        set_src(4'b1000, {12'h123, 36'h0}, {8'h80, 24'h0});
        sysclk_phase_i = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            sysclk_phase_i = 1'b0;
            if (k == 6) check("lat_c1_valid", {31'b0, trig_valid_o}, 0);
            if (k == 7) check("lat_c2_valid", {31'b0, trig_valid_o}, 1);
        end

        // Holdoff boundary: 7 lets the next slot through, 8 blocks it.
        for (int h = 7; h <= 8; h++) begin
            new_run(16'(h));
            slot(4'b0010, {12'h0, 12'h0, 12'h0E1, 12'h0}, {8'h0, 8'h0, 8'h11, 8'h0},
                 1'b1, 1'b0, -1);
            slot(4'b0010, {12'h0, 12'h0, 12'h0E2, 12'h0}, {8'h0, 8'h0, 8'h22, 8'h0},
                 1'b1, 1'b0, -1);
            set_src('0, '0, '0);
            check("hold_rej", {16'b0, holdoff_rej_o}, (h == 8) ? 1 : 0);
            trig_ready_i = 1'b1;
            n = 0;
            repeat (6) begin
                if (trig_valid_o) n++;
                step();
            end
            check("hold_entries", n, (h == 8) ? 1 : 2);
        end

        // Overflow: six RF slots with the sink stalled, then an in-order drain.
        new_run(16'd0);
        for (int s = 0; s < 6; s++) begin
            slot(4'b0001, {36'h0, 12'h100 + 12'(s)}, {24'h0, 8'(s)}, 1'b1, 1'b0, -1);
        end
        set_src('0, '0, '0);
        check("ovf_rej", {16'b0, overflow_rej_o}, 2);
        trig_ready_i = 1'b1;
        for (int s = 0; s < 4; s++) begin
            check("drain_valid", {31'b0, trig_valid_o}, 1);
            check("drain_addr", {20'b0, trig_o}, 32'h100 + s);
            step();
        end
        check("drain_empty", {31'b0, trig_valid_o}, 0);

        // Run stop keeps queued entries; reset mid-drain empties the queue.
        new_run(16'd0);
        slot(4'b0011, {24'h0, 12'h0E5, 12'h201}, '0, 1'b1, 1'b0, -1);
        slot(4'b0101, {12'h0, 12'h0C5, 12'h0, 12'h202}, '0, 1'b1, 1'b0, -1);
        set_src('0, '0, '0);
        check("pre_drop_coinc", {16'b0, coinc_rej_o}, 2);
        running_i = 1'b0;
        step();
        check("drop_coinc", {16'b0, coinc_rej_o}, 0);
        check("drop_valid", {31'b0, trig_valid_o}, 1);
        check("drop_head0", {20'b0, trig_o}, 32'h201);
        trig_ready_i = 1'b1;
        step();
        check("drop_head1", {20'b0, trig_o}, 32'h202);
        sysclk_rst_i = 1'b1;
        step();
        sysclk_rst_i = 1'b0;
        check("rst_mid_valid", {31'b0, trig_valid_o}, 0);
        trig_ready_i = 1'b0;
        repeat (2) step();
        check("rst_mid_empty", {31'b0, trig_valid_o}, 0);

        // Randomized slots: random sources, ready, run stops, missing pulses and resets.
        running_i = 1'b1;
        holdoff_i = 16'd0;
        for (int s = 0; s < 300; s++) begin
            logic [3:0]       v;
            logic [3:0][11:0] a;
            logic [3:0][7:0]  m;
            int               rst_at;
            if ($urandom_range(0, 14) == 0) begin
                running_i = 1'b0;
                holdoff_i = h_opts[$urandom_range(0, 6)];
            end else begin
                running_i = 1'b1;
            end
            for (int j = 0; j < 4; j++) begin
                v[j] = ($urandom_range(0, 9) < 3);
                a[j] = 12'($urandom);
                m[j] = 8'($urandom);
            end
            rf_en_i = ($urandom_range(0, 3) != 0);
            rst_at  = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 7)) : -1;
            slot(v, a, m, $urandom_range(0, 7) != 0, 1'b1, rst_at);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
